codec_i2s_rx: RTL

- I2S record-path deserializer for the codec ADC direction (ac_recdat/ac_reclrc), complementing the playback serializer inside the codec unit.
- Oversamples the codec-driven ac_bclk/ac_reclrc/ac_recdat in the AXI clock domain and assembles left/right samples into one stereo word.
- Presents each stereo word on a valid/ready interface toward the record FIFO/AXI register logic, with sticky overflow and frame-count status.

---
 rtl/codec_i2s_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/codec_i2s_rx.sv
// -----------------------------------------------------------------------------
// codec_i2s_rx
//
// I2S record-path deserializer. The codec drives ac_bclk, ac_reclrc and
// ac_recdat asynchronously. All three are oversampled in the AXI clock domain,
// and each left/right pair is assembled into one stereo word. That word is
// offered on a valid/ready interface to the record FIFO / register logic.
//
// Ports
//   s00_axi_aclk     system clock, at least 8x ac_bclk
//   s00_axi_aresetn  asynchronous active-low reset
//   rx_enable        capture enable; low forces IDLE
//   ac_bclk          codec bit clock (asynchronous)
//   ac_reclrc        codec record LR clock, 0 = left, 1 = right (asynchronous)
//   ac_recdat        codec record serial data, MSB first (asynchronous)
//   rec_data         {left, right} stereo word
//   rec_valid        rec_data valid
//   rec_ready        consumer accepts rec_data
//   overflow         sticky: a completed frame was dropped
//   overflow_clr     single-cycle clear of overflow (a same-cycle drop wins)
//   frame_count      frames delivered into rec_data, wraps
// -----------------------------------------------------------------------------
module codec_i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    rx_enable,
  input  logic                    ac_bclk,
  input  logic                    ac_reclrc,
  input  logic                    ac_recdat,
  output logic [2*DATA_WIDTH-1:0] rec_data,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic [CNT_WIDTH-1:0]    frame_count
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  state_t state_q;
  state_t state_d;

  // Each line gets two synchronizer flops followed by one delay flop.
  logic [2:0] bclk_pipe;
  logic [2:0] lrc_pipe;
  logic [2:0] dat_pipe;

  logic tick_q;
  logic lrc_s;
  logic dat_s;
  logic lrc_prev;

  logic                  boundary;
  logic                  lrc_rise;
  logic                  lrc_fall;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] slot_word;
  logic [IW-1:0]         bit_pos;
  logic [DATA_WIDTH-1:0] left_word;
  logic [2*DATA_WIDTH-1:0] frame_word;
  logic                  left_done;
  logic                  frame_done;
  logic                  commit_req;
  logic                  drop;

  // tick_q is registered from the synchronized stage. The delay stage of
  // lrc/dat therefore lines up with tick_q exactly, so the bit and the LR level
  // that go with a tick are both read from delay-stage outputs.
  assign lrc_s = lrc_pipe[2];
  assign dat_s = dat_pipe[2];

  // NOTE: every register here, data registers included, has a reset value.
  // None of them is a RAM, so nothing is left at X after reset.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bclk_pipe <= '0;
      lrc_pipe  <= '0;
      dat_pipe  <= '0;
      tick_q    <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only. Every flop
      // then samples its pre-edge value, whatever order the statements are in.
      bclk_pipe <= {bclk_pipe[1:0], ac_bclk};
      lrc_pipe  <= {lrc_pipe[1:0], ac_reclrc};
      dat_pipe  <= {dat_pipe[1:0], ac_recdat};
      tick_q    <= bclk_pipe[1] & ~bclk_pipe[2];
    end
  end

  assign boundary = tick_q && (lrc_s != lrc_prev);
  assign lrc_rise = boundary && lrc_s;
  assign lrc_fall = boundary && !lrc_s;

  // Slot word with the current bit merged in. On a boundary tick, this is the
  // finished word of the ending channel, because its LSB arrives one BCLK late.
  always_comb begin
    // NOTE: each combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    slot_word = sreg;
    bit_pos   = IW'(DATA_WIDTH - 1) - bit_cnt[IW-1:0];
    if (bit_cnt < CW'(DATA_WIDTH)) begin
      slot_word[bit_pos] = dat_s;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    left_done  = 1'b0;
    frame_done = 1'b0;
    if (!rx_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = SYNC;
        SYNC:  if (lrc_fall) state_d = LEFT;
        LEFT: begin
          if (lrc_rise) begin
            state_d   = RIGHT;
            left_done = 1'b1;
          end else if (lrc_fall) begin
            state_d = SYNC;
          end
        end
        RIGHT: begin
          if (lrc_fall) begin
            state_d    = LEFT;
            frame_done = 1'b1;
          end else if (lrc_rise) begin
            state_d = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      lrc_prev   <= 1'b0;
      bit_cnt    <= '0;
      sreg       <= '0;
      left_word  <= '0;
      frame_word <= '0;
      commit_req <= 1'b0;
    end else begin
      commit_req <= frame_done;
      // lrc_prev tracks the line even in IDLE. Re-enabling in the middle of a
      // slot therefore cannot see a stale level as a boundary.
      if (tick_q) lrc_prev <= lrc_s;

      if (state_q == IDLE) begin
        sreg    <= '0;
        bit_cnt <= '0;
      end else if (tick_q) begin
        if (boundary) begin
          // Clearing here leaves the LSBs of a short slot at zero.
          sreg    <= '0;
          bit_cnt <= '0;
        end else if (bit_cnt < CW'(DATA_WIDTH)) begin
          sreg    <= slot_word;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (left_done)  left_word  <= slot_word;
      if (frame_done) frame_word <= {left_word, slot_word};
    end
  end

  // A finished frame is dropped only when the previous word is still pending
  // and is not being accepted in the same cycle.
  assign drop = commit_req && rec_valid && !rec_ready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rec_data    <= '0;
      rec_valid   <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (commit_req && !drop) begin
        rec_data    <= frame_word;
        rec_valid   <= 1'b1;
        frame_count <= frame_count + CNT_WIDTH'(1);
      end else if (rec_valid && rec_ready) begin
        rec_valid <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
